// File: rtl/ysyx_24110006_sram.sv
// AXI4-lite word-addressed SRAM slave with programmable read/write latency.
// Independent read and write FSMs; out-of-range accesses answer SLVERR.
module ysyx_24110006_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 2,
  parameter int          WRITE_LAT   = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic [1:0]  o_axi_rresp,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  input  logic [31:0] i_axi_awaddr,
  input  logic        i_axi_awvalid,
  output logic        o_axi_awready,
  input  logic [31:0] i_axi_wdata,
  input  logic [7:0]  i_axi_wstrb,
  input  logic        i_axi_wvalid,
  output logic        o_axi_wready,
  output logic [1:0]  o_axi_bresp,
  output logic        o_axi_bvalid,
  input  logic        i_axi_bready
);
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- read channel ----------------
  rstate_e     rs_q, rs_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] roff;
  logic        r_ok;
  logic [IDX_W-1:0] ridx;

  // Offset wraps below ADDR_BASE, so one unsigned compare covers both bounds.
  assign roff = raddr_q - ADDR_BASE;
  assign r_ok = {1'b0, roff} < SPAN;
  assign ridx = roff[IDX_W+1:2];

  always_comb begin
    rs_d    = rs_q;
    rcnt_d  = rcnt_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (rs_q)
      R_IDLE: if (i_axi_arvalid) begin
        raddr_d = i_axi_araddr;
        rcnt_d  = 4'(READ_LAT);
        rs_d    = R_WAIT;
      end
      R_WAIT: if (rcnt_q == 4'd0) begin
        rdata_d = r_ok ? mem[ridx] : 32'h0;
        rresp_d = r_ok ? OKAY : SLVERR;
        rs_d    = R_RESP;
      end else begin
        rcnt_d = rcnt_q - 4'd1;
      end
      R_RESP: if (i_axi_rready) rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rs_q    <= R_IDLE;
      rcnt_q  <= 4'd0;
      raddr_q <= 32'h0;
      rdata_q <= 32'h0;
      rresp_q <= OKAY;
    end else begin
      rs_q    <= rs_d;
      rcnt_q  <= rcnt_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign o_axi_arready = (rs_q == R_IDLE);
  assign o_axi_rvalid  = (rs_q == R_RESP);
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;

  // ---------------- write channel ----------------
  wstate_e     ws_q, ws_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, commit;
  logic [31:0] woff;
  logic        w_ok;
  logic [IDX_W-1:0] widx;
  logic        unused_wstrb;

  assign unused_wstrb = ^i_axi_wstrb[7:4];
  assign woff = awaddr_q - ADDR_BASE;
  assign w_ok = {1'b0, woff} < SPAN;
  assign widx = woff[IDX_W+1:2];

  assign o_axi_awready = (ws_q == W_IDLE) && !aw_done_q;
  assign o_axi_wready  = (ws_q == W_IDLE) && !w_done_q;
  assign aw_hs = i_axi_awvalid && o_axi_awready;
  assign w_hs  = i_axi_wvalid && o_axi_wready;
  assign commit = (ws_q == W_WAIT) && (wcnt_q == 4'd0) && w_ok;

  always_comb begin
    ws_d      = ws_q;
    wcnt_d    = wcnt_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bresp_d   = bresp_q;
    case (ws_q)
      W_IDLE: begin
        if (aw_hs) begin
          awaddr_d  = i_axi_awaddr;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = i_axi_wdata;
          wstrb_d  = i_axi_wstrb[3:0];
          w_done_d = 1'b1;
        end
        // Latency counts from the later of the two handshakes.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wcnt_d    = 4'(WRITE_LAT);
          ws_d      = W_WAIT;
        end
      end
      W_WAIT: if (wcnt_q == 4'd0) begin
        bresp_d = w_ok ? OKAY : SLVERR;
        ws_d    = W_RESP;
      end else begin
        wcnt_d = wcnt_q - 4'd1;
      end
      W_RESP: if (i_axi_bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ws_q      <= W_IDLE;
      wcnt_q    <= 4'd0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      ws_q      <= ws_d;
      wcnt_q    <= wcnt_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bresp_q   <= bresp_d;
    end
  end

  assign o_axi_bvalid = (ws_q == W_RESP);
  assign o_axi_bresp  = bresp_q;

  // Storage is never reset; a same-edge read sees the pre-commit word.
  always_ff @(posedge i_clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24110006_sram.sv
// Directed + randomized bench for the AXI4-lite SRAM slave, checked against
// a word-array reference model with fixed-latency expectations.
module tb_ysyx_24110006_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;
  localparam int RL = 2;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  int edge_n = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  ysyx_24110006_sram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return x >= longint'(BASE) && x < longint'(BASE) + 4 * DEPTH;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return in_rng(a) ? mdl[idx_of(a)] : 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    if (in_rng(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[idx_of(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    bit awd, wd, ah, wh;
    int it, last;
    awd = 0; wd = 0; it = 0; last = 0; resp = 2'b11; lat = -1;
    while (!(awd && wd) && it < 50) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !awd && it >= aw_dly;
      wvalid  = !wd && it >= w_dly;
      if (wd && !awd) chk("wready_after_w", 32'(wready), 32'd0);
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      it++;
      if (ah) begin awd = 1; last = edge_n; end
      if (wh) begin wd = 1; last = edge_n; end
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", 32'(awd && wd), 32'd1);
    if (!(awd && wd)) return;
    it = 0;
    while (!bvalid && it < 40) begin tick(); it++; end
    chk("bvalid_seen", 32'(bvalid), 32'd1);
    lat = edge_n - last;
    resp = bresp;
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready && wready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
    int it, hs;
    d = 32'hx; resp = 2'b11; lat = -1;
    araddr = a;
    arvalid = 1;
    it = 0;
    while (!arready && it < 40) begin tick(); it++; end
    tick();
    arvalid = 0;
    hs = edge_n;
    it = 0;
    while (!rvalid && it < 40) begin
      chk("arready_busy", 32'(arready), 32'd0);
      tick(); it++;
    end
    chk("rvalid_seen", 32'(rvalid), 32'd1);
    lat = edge_n - hs;
    d = rdata;
    resp = rresp;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rhold_valid", 32'(rvalid), 32'd1);
      chk("rhold_data", rdata, d);
      chk("rhold_arready", 32'(arready), 32'd0);
    end
    rready = 1;
    chk("arready_in_resp", 32'(arready), 32'd0);
    tick();
    rready = 0;
    chk("arready_after_r", 32'(arready), 32'd1);
    chk("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic do_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] s, input int aw_dly, input int w_dly);
    logic [1:0] r;
    int l;
    axi_write(a, d, s, aw_dly, w_dly, r, l);
    chk({tag, "_bresp"}, 32'(r), in_rng(a) ? 32'd0 : 32'd2);
    chk({tag, "_blat"}, 32'(l), 32'(1 + WL));
    model_wr(a, d, s);
  endtask

  task automatic do_rd(input string tag, input logic [31:0] a, input int hold);
    logic [31:0] d;
    logic [1:0] r;
    int l;
    axi_read(a, hold, d, r, l);
    chk({tag, "_rresp"}, 32'(r), in_rng(a) ? 32'd0 : 32'd2);
    chk({tag, "_rdata"}, d, model_rd(a));
    chk({tag, "_rlat"}, 32'(l), 32'(1 + RL));
  endtask

  initial begin
    logic [31:0] rd_d, a, d;
    logic [1:0]  rd_r, wr_r;
    int rd_l, wr_l;
    logic [31:0] oor [4];
    oor[0] = 32'h7FFF_FFFC; oor[1] = 32'h8000_1000; oor[2] = 32'h0; oor[3] = 32'hFFFF_FFFC;

    rst_n = 0; arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = 0; awaddr = 0; wdata = 0; wstrb = 0;
    tick(); tick();
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({rresp, bresp}), 32'd0);
    rst_n = 1;
    tick();
    chk("rst_readies", 32'({arready, awready, wready}), 32'b111);

    do_wr("deadbeef", 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0);
    do_rd("deadbeef", 32'h8000_0010, 0);
    do_wr("w_first", 32'h8000_0010, 32'h0000_AA00, 8'hF2, 2, 0);
    chk("merge_model", mdl[4], 32'hDEAD_AAEF);
    do_rd("merge", 32'h8000_0010, 0);
    do_wr("strb0", 32'h8000_0010, 32'h1234_5678, 8'h00, 0, 0);
    do_rd("strb0", 32'h8000_0013, 0);

    do_wr("top_word", 32'h8000_0FFC, 32'hA5A5_5A5A, 8'h0F, 1, 0);
    do_rd("oor_hi", 32'h8000_1000, 0);
    do_wr("oor_lo", 32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F, 0, 0);
    do_rd("top_kept", 32'h8000_0FFC, 0);
    do_rd("base_word", 32'h8000_0010, 5);

    // Reset during write latency must leave the word untouched.
    do_wr("pre_rst", 32'h8000_0020, 32'hCAFE_F00D, 8'h0F, 0, 0);
    do_rd("pre_rst", 32'h8000_0020, 0);
    awaddr = 32'h8000_0020; wdata = 32'h1234_5678; wstrb = 8'h0F;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    chk("midrst_bvalid", 32'(bvalid), 32'd0);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    tick(); tick(); tick();
    rst_n = 1;
    tick();
    chk("postrst_readies", 32'({arready, awready, wready}), 32'b111);
    do_rd("post_rst", 32'h8000_0020, 0);

    // Same-cycle read sample and write commit.
    do_wr("conc_init", 32'h8000_0040, 32'h1111_1111, 8'h0F, 0, 0);
    fork
      axi_write(32'h8000_0040, 32'h2222_2222, 8'h0F, 0, 0, wr_r, wr_l);
      axi_read(32'h8000_0040, 0, rd_d, rd_r, rd_l);
    join
    chk("conc_old", rd_d, 32'h1111_1111);
    chk("conc_lat", 32'({8'(rd_l), 8'(wr_l)}), 32'({8'(1 + RL), 8'(1 + WL)}));
    chk("conc_resp", 32'({rd_r, wr_r}), 32'd0);
    model_wr(32'h8000_0040, 32'h2222_2222, 8'h0F);
    do_rd("conc_new", 32'h8000_0040, 0);

    for (int i = 0; i < 16; i++)
      do_wr("rinit", BASE + 32'h100 + 32'(4 * i), $urandom, 8'h0F, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)];
      else a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_wr("rnd_wr", a, d, 8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_rd("rnd_rd", a, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
